// File: rtl/eth_rx_byte.sv
// eth_rx_byte: RMII 100 Mb/s receive byte assembler.
// Packs dibits LSB-first into bytes while Rx_En frames the payload, and
// reports per-frame byte count and alignment/oversize/abort status on close.
//   i_clk         RMII 50 MHz reference clock
//   i_rst_n       asynchronous active-low reset
//   i_crs_dv      RMII carrier-sense / data-valid
//   i_rxd         RMII receive dibit
//   i_rx_en       frame enable from receive control (rising edge = first dibit)
//   o_byte        assembled byte, held until the next byte completes
//   o_byte_rdy    one-cycle pulse, o_byte valid
//   o_frame_end   one-cycle pulse, frame closed; status below valid
//   o_frame_bytes bytes emitted in the closed frame
//   o_align_err   frame closed on a partial byte
//   o_oversize    o_frame_bytes > P_MAX_BYTES
//   o_abort       frame cut by Rx_En drop
module eth_rx_byte #(
  parameter logic [15:0] P_MAX_BYTES = 16'd1522
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_crs_dv,
  input  logic [1:0]  i_rxd,
  input  logic        i_rx_en,
  output logic [7:0]  o_byte,
  output logic        o_byte_rdy,
  output logic        o_frame_end,
  output logic [15:0] o_frame_bytes,
  output logic        o_align_err,
  output logic        o_oversize,
  output logic        o_abort
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_LOW1 = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      r_state;
  logic        r_rx_en_prev;
  logic        r_armed;     // Rx_En has been sampled low since reset
  logic        r_abort;
  logic [1:0]  r_dib_idx;   // next dibit slot == total accepted dibits mod 4
  logic [5:0]  r_sr;        // lower three dibits of the byte in progress
  logic [15:0] r_byte_cnt;

  logic        w_start;
  logic        w_accept;
  logic [1:0]  w_idx;
  logic [15:0] w_cnt;

  // A start needs a true rising edge; r_armed blocks an Rx_En held high
  // through reset release from looking like one.
  assign w_start  = (r_state == S_IDLE) & i_rx_en & ~r_rx_en_prev & r_armed;
  assign w_accept = w_start
                  | ((r_state == S_DATA) & (~i_crs_dv | i_rx_en))
                  | ((r_state == S_LOW1) & i_crs_dv);
  assign w_idx    = w_start ? 2'd0 : r_dib_idx;
  assign w_cnt    = w_start ? 16'd0 : r_byte_cnt;

  // Datapath and FSM
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= S_IDLE;
      r_rx_en_prev  <= 1'b0;
      r_armed       <= 1'b0;
      r_abort       <= 1'b0;
      r_dib_idx     <= 2'd0;
      r_sr          <= 6'd0;
      r_byte_cnt    <= 16'd0;
      o_byte        <= 8'd0;
      o_byte_rdy    <= 1'b0;
      o_frame_end   <= 1'b0;
      o_frame_bytes <= 16'd0;
      o_align_err   <= 1'b0;
      o_oversize    <= 1'b0;
      o_abort       <= 1'b0;
    end else begin
      r_rx_en_prev <= i_rx_en;
      if (!i_rx_en) r_armed <= 1'b1;
      o_byte_rdy  <= 1'b0;
      o_frame_end <= 1'b0;

      if (w_start) r_byte_cnt <= 16'd0;

      if (w_accept) begin
        r_dib_idx <= w_idx + 2'd1;
        case (w_idx)
          2'd0: r_sr[1:0] <= i_rxd;
          2'd1: r_sr[3:2] <= i_rxd;
          2'd2: r_sr[5:4] <= i_rxd;
          default: begin
            o_byte     <= {i_rxd, r_sr};
            o_byte_rdy <= 1'b1;
            r_byte_cnt <= (w_cnt == 16'hFFFF) ? w_cnt : w_cnt + 16'd1;
          end
        endcase
      end

      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_abort <= 1'b0;
            r_state <= S_DATA;
          end
        end
        S_DATA: begin
          if (!i_crs_dv) begin
            r_state <= S_LOW1;
          end else if (!i_rx_en) begin
            r_abort <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_LOW1: begin
          r_state <= i_crs_dv ? S_DATA : S_DONE;
        end
        default: begin
          // Exactly one trailing dibit (CRS_DV stretch) is expected on a clean close.
          o_frame_end   <= 1'b1;
          o_frame_bytes <= r_byte_cnt;
          o_abort       <= r_abort;
          o_align_err   <= ~r_abort & (r_dib_idx != 2'd1);
          o_oversize    <= (r_byte_cnt > P_MAX_BYTES);
          r_state       <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_eth_rx_byte.sv
// tb_eth_rx_byte: directed self-checking bench for eth_rx_byte.
module tb_eth_rx_byte;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_crs_dv;
  logic [1:0]  i_rxd;
  logic        i_rx_en;
  logic [7:0]  o_byte;
  logic        o_byte_rdy;
  logic        o_frame_end;
  logic [15:0] o_frame_bytes;
  logic        o_align_err;
  logic        o_oversize;
  logic        o_abort;

  eth_rx_byte dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_crs_dv      (i_crs_dv),
    .i_rxd         (i_rxd),
    .i_rx_en       (i_rx_en),
    .o_byte        (o_byte),
    .o_byte_rdy    (o_byte_rdy),
    .o_frame_end   (o_frame_end),
    .o_frame_bytes (o_frame_bytes),
    .o_align_err   (o_align_err),
    .o_oversize    (o_oversize),
    .o_abort       (o_abort)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0]  q[$];
  int          fe_cnt = 0;
  int          coll_cnt = 0;
  logic [15:0] cap_fb;
  logic        cap_align;
  logic        cap_over;
  logic        cap_abort;

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Output monitor, sampled mid-cycle
  always @(negedge i_clk) begin
    if (o_byte_rdy) q.push_back(o_byte);
    if (o_byte_rdy && o_frame_end) coll_cnt++;
    if (o_frame_end) begin
      fe_cnt++;
      cap_fb    = o_frame_bytes;
      cap_align = o_align_err;
      cap_over  = o_oversize;
      cap_abort = o_abort;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drv(input logic crs, input logic en, input logic [1:0] d);
    i_crs_dv = crs;
    i_rx_en  = en;
    i_rxd    = d;
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drv(1'b0, 1'b0, 2'b00);
  endtask

  // Frame of nbytes incrementing from 'first'; optional CRS_DV toggle on the
  // last byte, extra trailing dibits, or an Rx_En-drop abort instead of close.
  task automatic send_frame(input int nbytes, input logic [7:0] first, input bit toggle_end,
                            input int extra, input bit abort_it);
    logic [7:0] b;
    logic       crs;
    q.delete();
    idle(2);
    for (int i = 0; i < nbytes; i++) begin
      b = first + 8'(i);
      for (int k = 0; k < 4; k++) begin
        crs = (toggle_end && i == nbytes - 1) ? (k % 2 == 1) : 1'b1;
        drv(crs, 1'b1, b[2*k +: 2]);
      end
    end
    for (int e = 0; e < extra; e++) drv(1'b1, 1'b1, 2'b10);
    if (abort_it) begin
      drv(1'b1, 1'b0, 2'b01);
    end else begin
      drv(1'b0, 1'b1, 2'b11);
      drv(1'b0, 1'b0, 2'b00);
    end
    idle(3);
  endtask

  int fe_before;

  initial begin
    i_rst_n  = 1'b0;
    i_crs_dv = 1'b0;
    i_rx_en  = 1'b0;
    i_rxd    = 2'b00;
    #23;
    chk("rst_byte",     32'(o_byte), 32'h0);
    chk("rst_byte_rdy", 32'(o_byte_rdy), 32'h0);
    chk("rst_fe",       32'(o_frame_end), 32'h0);
    chk("rst_fb",       32'(o_frame_bytes), 32'h0);
    chk("rst_flags",    32'({o_align_err, o_oversize, o_abort}), 32'h0);
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;

    // Single byte 01,10,11,00 -> 0x39
    fe_before = fe_cnt;
    send_frame(1, 8'h39, 1'b0, 0, 1'b0);
    chk("f1_nbytes", 32'(q.size()), 32'd1);
    chk("f1_byte",   32'(q[0]), 32'h39);
    chk("f1_fe",     32'(fe_cnt - fe_before), 32'd1);
    chk("f1_fb",     32'(cap_fb), 32'd1);
    chk("f1_align",  32'(cap_align), 32'd0);
    chk("f1_abort",  32'(cap_abort), 32'd0);
    chk("f1_over",   32'(cap_over), 32'd0);
    chk("f1_hold",   32'(o_byte), 32'h39);

    // 64 incrementing bytes, CRS_DV toggling on last byte
    fe_before = fe_cnt;
    send_frame(64, 8'h00, 1'b1, 0, 1'b0);
    chk("f64_nbytes", 32'(q.size()), 32'd64);
    for (int i = 0; i < 64; i++) chk($sformatf("f64_byte%0d", i), 32'(q[i]), 32'(i));
    chk("f64_fe",    32'(fe_cnt - fe_before), 32'd1);
    chk("f64_fb",    32'(cap_fb), 32'd64);
    chk("f64_align", 32'(cap_align), 32'd0);

    // 5 bytes + 2 dibits -> misaligned close
    send_frame(5, 8'hC0, 1'b0, 2, 1'b0);
    chk("fal_nbytes", 32'(q.size()), 32'd5);
    chk("fal_fb",     32'(cap_fb), 32'd5);
    chk("fal_align",  32'(cap_align), 32'd1);
    chk("fal_abort",  32'(cap_abort), 32'd0);

    // Rx_En drop after 14 bytes
    fe_before = fe_cnt;
    send_frame(14, 8'h10, 1'b0, 0, 1'b1);
    chk("fab_fe",     32'(fe_cnt - fe_before), 32'd1);
    chk("fab_nbytes", 32'(q.size()), 32'd14);
    chk("fab_fb",     32'(cap_fb), 32'd14);
    chk("fab_abort",  32'(cap_abort), 32'd1);
    chk("fab_align",  32'(cap_align), 32'd0);

    // 1523 bytes -> oversize
    send_frame(1523, 8'h00, 1'b0, 0, 1'b0);
    chk("fov_nbytes", 32'(q.size()), 32'd1523);
    chk("fov_fb",     32'(cap_fb), 32'd1523);
    chk("fov_over",   32'(cap_over), 32'd1);
    chk("fov_align",  32'(cap_align), 32'd0);
    chk("fov_abort",  32'(cap_abort), 32'd0);

    // Reset mid byte 3 with Rx_En held high through release
    idle(2);
    for (int i = 0; i < 10; i++) drv(1'b1, 1'b1, 2'b01);
    fe_before = fe_cnt;
    i_rst_n = 1'b0;
    #1;
    chk("mrst_byte", 32'(o_byte), 32'h0);
    chk("mrst_fb",   32'(o_frame_bytes), 32'h0);
    chk("mrst_flag", 32'({o_byte_rdy, o_frame_end, o_align_err, o_oversize, o_abort}), 32'h0);
    q.delete();
    @(posedge i_clk);
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    for (int i = 0; i < 12; i++) drv(1'b1, 1'b1, 2'b11);
    idle(3);
    chk("mrst_nobytes", 32'(q.size()), 32'd0);
    chk("mrst_nofe",    32'(fe_cnt - fe_before), 32'd0);

    fe_before = fe_cnt;
    send_frame(1, 8'hA5, 1'b0, 0, 1'b0);
    chk("post_nbytes", 32'(q.size()), 32'd1);
    chk("post_byte",   32'(q[0]), 32'hA5);
    chk("post_fe",     32'(fe_cnt - fe_before), 32'd1);
    chk("post_fb",     32'(cap_fb), 32'd1);

    chk("no_collision", 32'(coll_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/eth_rx_byte.md
ETH_RX_BYTE -- requirements
Module: eth_rx_byte

Interface
REQ-001 Parameter P_MAX_BYTES, default 16'd1522, max legal bytes per frame; a larger count sets Oversize.
REQ-002 Clk  in  1  RMII 50 MHz reference clock; all logic on posedge.
REQ-003 Rst_n  in  1  reset, asynchronous, active-low.
REQ-004 Crs_Dv  in  1  RMII carrier-sense/data-valid.
REQ-005 Rxd  in  2  RMII receive dibit.
REQ-006 Rx_En  in  1  from receive control; a rising edge marks the first data dibit after SFD.
REQ-007 Byte  out  8  assembled byte.
REQ-008 Byte_Rdy  out  1  one-cycle pulse; Byte is valid.
REQ-009 Frame_End  out  1  one-cycle pulse; the frame has closed.
REQ-010 Frame_Bytes  out  16  bytes emitted in the frame; valid with Frame_End.
REQ-011 Align_Err  out  1  partial-byte error; valid with Frame_End.
REQ-012 Oversize  out  1  Frame_Bytes > P_MAX_BYTES; valid with Frame_End.
REQ-013 Abort  out  1  frame cut by Rx_En drop; valid with Frame_End.

Function
REQ-014 The block shall be 100 Mb/s only: one dibit per Clk in DATA/LOW1.
REQ-015 FSM states shall be IDLE, DATA, LOW1, DONE.
REQ-016 IDLE -> DATA when Rx_En=1 and the registered previous Rx_En=0; the dibit on that edge shall be accepted as dibit 0; the dibit counter and byte counter clear.
REQ-017 DATA with Crs_Dv=1 and Rx_En=1: accept the dibit and stay.
REQ-018 DATA with Crs_Dv=0: accept the dibit (regardless of Rx_En) and go to LOW1.
REQ-019 DATA with Crs_Dv=1 and Rx_En=0: accept nothing, set the abort flag, and go to DONE.
REQ-020 LOW1 with Crs_Dv=1: accept the dibit (end-of-frame CRS_DV toggle) and return to DATA; Rx_En is ignored in LOW1.
REQ-021 LOW1 with Crs_Dv=0: accept nothing and go to DONE.
REQ-022 DONE: pulse Frame_End for one cycle and go to IDLE.
REQ-023 Dibit packing shall be LSB first: dibit k of a byte loads Byte[2k+1:2k], k=0..3.
REQ-024 Byte and Byte_Rdy shall be registered: Byte_Rdy=1 in the cycle after the edge that accepted dibit 3.
REQ-025 Byte shall hold its value until the next byte completes.
REQ-026 Frame_Bytes shall increment per emitted byte and saturate at 16'hFFFF.
REQ-027 Align_Err=1 iff (total accepted dibits mod 4) != 1 at a non-abort close; the single trailing dibit is the normal CRS_DV stretch artifact, is discarded, and no byte is emitted for it.
REQ-028 Align_Err=0 when Abort=1.
REQ-029 Frame_End, Frame_Bytes, Align_Err, Oversize, and Abort shall be updated on the same edge.
REQ-030 Frame_Bytes and the flags shall hold until the next Frame_End.
REQ-031 Byte_Rdy and Frame_End shall never be high in the same cycle; the last Byte_Rdy precedes Frame_End by at least 1 cycle.
REQ-032 Rx_En held high after DONE shall not restart a frame; a fresh rising edge is required.

Reset
REQ-033 Rst_n=0 shall immediately force the state to IDLE and clear all counters, the previous-Rx_En register, and all outputs to 0, regardless of clock.
REQ-034 Reset mid-frame shall discard the partial frame with no Frame_End.
REQ-035 The first frame after reset release requires an Rx_En rising edge.

Verification
REQ-036 Rx_En rises with dibits 01,10,11,00, then Crs_Dv=0 for 2 cycles -> one Byte_Rdy with Byte=8'h39, then Frame_End with Frame_Bytes=1, Align_Err=0, Abort=0.
REQ-037 64-byte frame of incrementing bytes, Crs_Dv toggling 0/1 on the last 4 dibits -> 64 Byte_Rdy pulses with Byte=0..63 in order; Frame_End with Frame_Bytes=64 and Align_Err=0.
REQ-038 Frame ending after 5 bytes + 2 dibits, then Crs_Dv low -> Frame_Bytes=5 and Align_Err=1.
REQ-039 Rx_En drops while Crs_Dv=1 after byte 14 -> Frame_End with Abort=1, Frame_Bytes=14, Align_Err=0; no further Byte_Rdy.
REQ-040 1523-byte frame -> Oversize=1 and Frame_Bytes=1523.
REQ-041 Rst_n asserted mid-byte 3 -> outputs 0 within the same cycle and no Frame_End; Rx_En held high through release starts no frame until it toggles low then high.
